// File: rtl/spi_native_pkg.sv
// spi_native_pkg: shared frame layout, FSM states and frame packing for the native SPI link
package spi_native_pkg;
    localparam int FRAME_W       = 27;
    localparam int RD_BIT        = 26;
    localparam int ADDR_MSB      = 25;
    localparam int ADDR_LSB      = 18;
    localparam int DATA_W        = 16;
    localparam int RD_FIRST_EDGE = 12;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} spi_state_t;

    function automatic logic [FRAME_W-1:0] pack_frame(
        input logic              rd,
        input logic [7:0]        addr,
        input logic [DATA_W-1:0] data
    );
        return {rd, addr, 2'b00, data};
    endfunction
endpackage

// File: rtl/spi_master_native_if.sv
// spi_master_native_if: request/response port of the native SPI master
interface spi_master_native_if;
    import spi_native_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic              req_rd;
    logic [7:0]        req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;

    modport master(output req_valid, req_rd, req_addr, req_wdata, input req_ready, rsp_valid, rsp_rdata, busy);
    modport slave(input req_valid, req_rd, req_addr, req_wdata, output req_ready, rsp_valid, rsp_rdata, busy);
endinterface

// File: rtl/spi_native_sck_gen.sv
// spi_native_sck_gen: SCK divider producing the serial clock plus edge pulses for the cycle an edge is generated
module spi_native_sck_gen #(
    parameter int HALF_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic sck,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam logic [7:0] DIV_TOP = 8'(HALF_DIV - 1);
    logic [7:0] div_cnt;
    logic       wrap;

    assign wrap       = run && div_cnt == DIV_TOP;
    assign rise_pulse = wrap && !sck;
    assign fall_pulse = wrap && sck;

    // divider wraps every HALF_DIV cycles and toggles sck; both held cleared while not running
    always_ff @(posedge clk) begin
        if (rst || !run) begin
            div_cnt <= '0;
            sck     <= 1'b0;
        end else begin
            div_cnt <= wrap ? '0 : div_cnt + 8'd1;
            sck     <= wrap ? ~sck : sck;
        end
    end
endmodule

// File: rtl/spi_master_native.sv
// spi_master_native: serializes single register requests into 27-bit native SPI frames and returns completions
module spi_master_native
    import spi_native_pkg::*;
#(
    parameter int HALF_DIV = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_GAP   = 4
) (
    input  logic                clk,
    input  logic                rst,
    spi_master_native_if.slave  req,
    output logic                spi_sck,
    output logic                spi_cs,
    output logic                spi_mosi,
    input  logic                spi_miso
);
    localparam logic [15:0] SETUP_TOP   = 16'(CS_SETUP - 1);
    localparam logic [15:0] HOLD_TOP    = 16'(HALF_DIV - 1);
    localparam logic [15:0] GAP_TOP     = 16'(CS_GAP - 1);
    localparam logic [4:0]  LAST_RD_BIT = 5'(FRAME_W - RD_FIRST_EDGE);

    if (HALF_DIV < 2 || HALF_DIV > 255 || CS_SETUP < 1 || CS_GAP < 2) begin : g_param_check
        $error("spi_master_native: illegal HALF_DIV/CS_SETUP/CS_GAP");
    end

    spi_state_t         state;
    logic [FRAME_W-1:0] frame;
    logic [FRAME_W-2:0] sr;
    logic [4:0]         bit_idx;
    logic [15:0]        tcnt;
    logic               rd_q;
    logic [DATA_W-1:0]  rdata;
    logic               rise;
    logic               fall;

    assign req.req_ready = state == IDLE && !rst;
    assign req.busy      = state != IDLE;
    assign frame         = pack_frame(req.req_rd, req.req_addr, req.req_rd ? {DATA_W{1'b0}} : req.req_wdata);

    spi_native_sck_gen #(.HALF_DIV(HALF_DIV)) u_sck_gen (
        .clk        (clk),
        .rst        (rst),
        .run        (state == SHIFT),
        .sck        (spi_sck),
        .rise_pulse (rise),
        .fall_pulse (fall)
    );

    // frame sequencer: latch request, hold CS setup, shift 27 bits, hold, then enforce the CS gap
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            spi_cs        <= 1'b1;
            spi_mosi      <= 1'b0;
            req.rsp_valid <= 1'b0;
            req.rsp_rdata <= '0;
            sr            <= '0;
            bit_idx       <= '0;
            tcnt          <= '0;
            rd_q          <= 1'b0;
            rdata         <= '0;
        end else begin
            req.rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req.req_valid) begin
                    state    <= SETUP;
                    spi_cs   <= 1'b0;
                    spi_mosi <= frame[RD_BIT];
                    sr       <= frame[FRAME_W-2:0];
                    rd_q     <= req.req_rd;
                    bit_idx  <= 5'(RD_BIT);
                    tcnt     <= '0;
                    rdata    <= '0;
                end
                SETUP: begin
                    tcnt <= tcnt + 16'd1;
                    if (tcnt == SETUP_TOP) begin
                        state <= SHIFT;
                        tcnt  <= '0;
                    end
                end
                SHIFT: begin
                    if (rise && bit_idx <= LAST_RD_BIT) rdata <= {rdata[DATA_W-2:0], spi_miso};
                    if (fall) begin
                        sr       <= sr << 1;
                        spi_mosi <= sr[FRAME_W-2];
                        bit_idx  <= bit_idx - 5'd1;
                        if (bit_idx == 5'd0) state <= HOLD;
                    end
                end
                HOLD: begin
                    tcnt <= tcnt + 16'd1;
                    if (tcnt == HOLD_TOP) begin
                        state         <= GAP;
                        tcnt          <= '0;
                        spi_cs        <= 1'b1;
                        req.rsp_valid <= 1'b1;
                        req.rsp_rdata <= rd_q ? rdata : '0;
                    end
                end
                GAP: begin
                    tcnt <= tcnt + 16'd1;
                    if (tcnt == GAP_TOP) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
